sha3_absorb_pad: RTL and testbench

Parametrised absorb front-end for the SHA3/SHAKE core. It accepts a message as a stream of 64-bit lanes with a valid/ready handshake and a byte-accurate last word. It packs lanes into a rate block sized by mode, inserts the FIPS-202 domain/pad10*1 padding itself, and hands complete 1600-bit blocks (capacity zeroed) to the permutation through a second valid/ready handshake.

---
 rtl/sha3_absorb_pad_if.sv | 26 ++
 rtl/sha3_absorb_pad.sv | 184 ++++++++++++++++++
 tb/tb_sha3_absorb_pad.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/sha3_absorb_pad_if.sv
// Lane-stream input and padded-block output handshakes of the SHA3 absorb front-end.
// The design drives through the slave modport; the bench drives through master.
interface sha3_absorb_pad_if #(
  parameter int LANE_W  = 64,
  parameter int STATE_W = 1600
);
  logic [LANE_W-1:0]  din;
  logic               din_valid;
  logic               din_ready;
  logic               din_last;
  logic [3:0]         din_bytes;
  logic [STATE_W-1:0] dout;
  logic               block_valid;
  logic               block_ready;
  logic               block_last;

  modport slave (
    input  din, din_valid, din_last, din_bytes, block_ready,
    output din_ready, dout, block_valid, block_last
  );

  modport master (
    output din, din_valid, din_last, din_bytes, block_ready,
    input  din_ready, dout, block_valid, block_last
  );
endinterface

// File: rtl/sha3_absorb_pad.sv
// SHA3/SHAKE absorb front-end: packs 64-bit lanes into a rate block, applies
// domain + pad10*1 padding, and presents full 1600-bit blocks with capacity zeroed.
module sha3_absorb_pad #(
  parameter int          LANE_W    = 64,
  parameter int          STATE_W   = 1600,
  parameter int          MAX_LANES = 21,
  parameter logic [7:0]  SHA3_DS   = 8'h06,
  parameter logic [7:0]  SHAKE_DS  = 8'h1F
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] mode_sel_i,
  output logic       busy,
  sha3_absorb_pad_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL, S_PADONLY} state_t;

  localparam logic [LANE_W-1:0] PAD_TOP = {8'h80, {(LANE_W-8){1'b0}}};

  function automatic logic [4:0] rate_of(input logic [2:0] m);
    case (m)
      3'd0:    rate_of = 5'd21;
      3'd1:    rate_of = 5'd17;
      3'd2:    rate_of = 5'd9;
      3'd3:    rate_of = 5'd13;
      3'd5:    rate_of = 5'd18;
      default: rate_of = 5'd17;
    endcase
  endfunction

  function automatic logic [7:0] ds_of(input logic [2:0] m);
    ds_of = (m < 3'd2) ? SHAKE_DS : SHA3_DS;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_cnt, w_cnt_nxt;
  logic [LANE_W-1:0] r_lane [MAX_LANES];
  logic [LANE_W-1:0] w_lane_nxt [MAX_LANES];
  logic [4:0]        r_rate, w_rate, w_rate_nxt;
  logic [7:0]        r_ds, w_ds, w_ds_nxt;
  logic              r_pad_pending, w_pad_nxt;
  logic              r_block_last, w_last_nxt;
  logic              r_din_ready, r_block_valid, r_busy;
  logic [3:0]        w_n;
  logic [LANE_W-1:0] w_word;

  // Mode is taken live only for the first word; afterwards the latched copy rules.
  assign w_rate = (r_state == S_IDLE) ? rate_of(mode_sel_i) : r_rate;
  assign w_ds   = (r_state == S_IDLE) ? ds_of(mode_sel_i)   : r_ds;
  assign w_n    = (bus.din_bytes > 4'd8) ? 4'd8 : bus.din_bytes;

  // Incoming lane with tail bytes masked and the domain byte inserted after the data.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < 8; k++) begin
      if (!bus.din_last) begin
        w_word[8*k +: 8] = bus.din[8*k +: 8];
      end else if (4'(k) < w_n) begin
        w_word[8*k +: 8] = bus.din[8*k +: 8];
      end else if (4'(k) == w_n) begin
        w_word[8*k +: 8] = w_ds;
      end else begin
        w_word[8*k +: 8] = 8'h00;
      end
    end
  end

  // Next-state, lane buffer update and padding placement.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lane_nxt  = r_lane;
    w_rate_nxt  = r_rate;
    w_ds_nxt    = r_ds;
    w_pad_nxt   = r_pad_pending;
    w_last_nxt  = r_block_last;
    case (r_state)
      S_IDLE, S_FILL: begin
        if (bus.din_valid && r_din_ready) begin
          w_rate_nxt        = w_rate;
          w_ds_nxt          = w_ds;
          w_lane_nxt[r_cnt] = w_word;
          if (!bus.din_last) begin
            if (r_cnt == w_rate - 5'd1) begin
              w_state_nxt = S_FULL;
              w_last_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_FILL;
              w_cnt_nxt   = r_cnt + 5'd1;
            end
          end else if (w_n < 4'd8) begin
            w_lane_nxt[w_rate - 5'd1] = w_lane_nxt[w_rate - 5'd1] | PAD_TOP;
            w_state_nxt = S_FULL;
            w_last_nxt  = 1'b1;
          end else if (r_cnt + 5'd1 < w_rate) begin
            w_lane_nxt[r_cnt + 5'd1]  = {{(LANE_W-8){1'b0}}, w_ds};
            w_lane_nxt[w_rate - 5'd1] = w_lane_nxt[w_rate - 5'd1] | PAD_TOP;
            w_state_nxt = S_FULL;
            w_last_nxt  = 1'b1;
          end else begin
            // Message ends exactly on a block boundary: padding needs a block of its own.
            w_state_nxt = S_FULL;
            w_last_nxt  = 1'b0;
            w_pad_nxt   = 1'b1;
          end
        end else begin
          w_state_nxt = r_state;
        end
      end
      S_FULL: begin
        if (bus.block_ready) begin
          for (int i = 0; i < MAX_LANES; i++) begin
            w_lane_nxt[i] = '0;
          end
          w_cnt_nxt  = 5'd0;
          w_pad_nxt  = 1'b0;
          w_last_nxt = 1'b0;
          if (r_block_last) begin
            w_state_nxt = S_IDLE;
          end else if (r_pad_pending) begin
            w_state_nxt = S_PADONLY;
          end else begin
            w_state_nxt = S_FILL;
          end
        end else begin
          w_state_nxt = S_FULL;
        end
      end
      S_PADONLY: begin
        w_lane_nxt[0]             = {{(LANE_W-8){1'b0}}, r_ds};
        w_lane_nxt[r_rate - 5'd1] = w_lane_nxt[r_rate - 5'd1] | PAD_TOP;
        w_state_nxt = S_FULL;
        w_last_nxt  = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, buffer and registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 5'd0;
      r_rate        <= 5'd17;
      r_ds          <= SHA3_DS;
      r_pad_pending <= 1'b0;
      r_block_last  <= 1'b0;
      r_din_ready   <= 1'b0;
      r_block_valid <= 1'b0;
      r_busy        <= 1'b0;
      for (int i = 0; i < MAX_LANES; i++) begin
        r_lane[i] <= '0;
      end
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_rate        <= w_rate_nxt;
      r_ds          <= w_ds_nxt;
      r_pad_pending <= w_pad_nxt;
      r_block_last  <= w_last_nxt;
      r_din_ready   <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FILL);
      r_block_valid <= (w_state_nxt == S_FULL);
      r_busy        <= (w_state_nxt != S_IDLE);
      r_lane        <= w_lane_nxt;
    end
  end

  assign bus.din_ready   = r_din_ready;
  assign bus.block_valid = r_block_valid;
  assign bus.block_last  = r_block_last;
  assign busy            = r_busy;

  for (genvar i = 0; i < STATE_W / LANE_W; i++) begin : g_dout
    if (i < MAX_LANES) begin : g_lane
      assign bus.dout[LANE_W*i +: LANE_W] = r_lane[i];
    end else begin : g_zero
      assign bus.dout[LANE_W*i +: LANE_W] = '0;
    end
  end

endmodule

// File: tb/tb_sha3_absorb_pad.sv
// Bench for sha3_absorb_pad: directed and random messages checked against a
// byte-level FIPS-202 padding model (message bytes, DS, zeros, final 0x80).
module tb_sha3_absorb_pad;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] mode_sel = 3'd0;
  logic       busy;

  always #5 clk = ~clk;

  sha3_absorb_pad_if bus ();

  sha3_absorb_pad dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode_sel_i (mode_sel),
    .busy       (busy),
    .bus        (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [1599:0] exp_blk[$];
  logic          exp_last[$];
  logic [1599:0] got_blk[$];
  int rate_tab[8] = '{21, 17, 9, 13, 17, 18, 17, 17};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int diff_lane(input logic [1599:0] a, input logic [1599:0] b);
    for (int i = 0; i < 25; i++) begin
      if (a[64*i +: 64] !== b[64*i +: 64]) return i;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_block(input string tag, input logic [1599:0] got, input logic [1599:0] exp);
    int l;
    l = diff_lane(got, exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s lane %0d: observed %h expected %h", tag, l, got[64*l +: 64], exp[64*l +: 64]);
    end
  endtask

  // Reference model: pad the byte string and cut it into rate-sized blocks.
  task automatic build_exp(input int mode, input logic [63:0] words[$], input int nb);
    byte unsigned q[$];
    int rb, cnt;
    logic [7:0] ds;
    logic [1599:0] b;
    rb = rate_tab[mode] * 8;
    ds = (mode < 2) ? 8'h1F : 8'h06;
    for (int w = 0; w < words.size(); w++) begin
      cnt = (w == words.size() - 1) ? ((nb > 8) ? 8 : nb) : 8;
      for (int k = 0; k < cnt; k++) q.push_back(words[w][8*k +: 8]);
    end
    q.push_back(ds);
    while (q.size() % rb != 0) q.push_back(8'h00);
    q[q.size()-1] = q[q.size()-1] | 8'h80;
    for (int s = 0; s < q.size(); s += rb) begin
      b = '0;
      for (int j = 0; j < rb; j++) b[8*j +: 8] = q[s+j];
      exp_blk.push_back(b);
      exp_last.push_back(s + rb >= q.size());
    end
  endtask

  task automatic consume(input string tag, input int hold);
    int t;
    logic [1599:0] e;
    logic el;
    t = 0;
    while (!bus.block_valid && t < 200) begin
      tick();
      t++;
    end
    check({tag, "_blk_timeout"}, 64'(t < 200), 64'd1);
    if (t < 200) begin
      check({tag, "_exp_avail"}, 64'(exp_blk.size() > 0), 64'd1);
      if (exp_blk.size() > 0) begin
        e  = exp_blk.pop_front();
        el = exp_last.pop_front();
        for (int h = 0; h < hold; h++) begin
          tick();
          check_block({tag, "_hold_dout"}, bus.dout, e);
          check({tag, "_hold_valid"}, 64'(bus.block_valid), 64'd1);
          check({tag, "_hold_ready"}, 64'(bus.din_ready), 64'd0);
        end
        check_block({tag, "_dout"}, bus.dout, e);
        check({tag, "_last"}, 64'(bus.block_last), 64'(el));
        got_blk.push_back(bus.dout);
      end
      bus.block_ready = 1'b1;
      tick();
      bus.block_ready = 1'b0;
    end
  endtask

  task automatic send_msg(input string tag, input int mode, input int mode2, input int switch_at,
                          input logic [63:0] words[$], input int nb, input int hold);
    int t;
    build_exp(mode, words, nb);
    for (int w = 0; w < words.size(); w++) begin
      mode_sel      = (w >= switch_at) ? 3'(mode2) : 3'(mode);
      bus.din       = words[w];
      bus.din_last  = (w == words.size() - 1);
      bus.din_bytes = (w == words.size() - 1) ? 4'(nb) : 4'($urandom_range(0, 8));
      bus.din_valid = 1'b1;
      t = 0;
      while (!bus.din_ready && t < 200) begin
        tick();
        t++;
      end
      check({tag, "_rdy_timeout"}, 64'(t < 200), 64'd1);
      tick();
      bus.din_valid = 1'b0;
      if (w == 0) check({tag, "_busy"}, 64'(busy), 64'd1);
      if (bus.block_valid) consume(tag, (w == words.size() - 1) ? hold : 0);
    end
    while (exp_blk.size() > 0) consume({tag, "_pad"}, 0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_idle_ready"}, 64'(bus.din_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] ws[$];
    bus.din = '0; bus.din_valid = 1'b0; bus.din_last = 1'b0;
    bus.din_bytes = 4'd0; bus.block_ready = 1'b0;
    repeat (3) tick();
    check("rst_ready", 64'(bus.din_ready), 64'd0);
    check("rst_valid", 64'(bus.block_valid), 64'd0);
    check("rst_last", 64'(bus.block_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check_block("rst_dout", bus.dout, 1600'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(bus.din_ready), 64'd1);

    // SHA3-256 "abc"
    ws = {64'hFFFF_FF00_0063_6261};
    send_msg("abc", 4, 4, 99, ws, 3, 0);
    check("abc_lane0", got_blk[0][63:0], 64'h0000_0000_0663_6261);
    check("abc_lane16", got_blk[0][64*16 +: 64], 64'h8000_0000_0000_0000);

    // SHA3-512, nine full words: extra padding-only block
    ws.delete();
    for (int i = 0; i < 9; i++) ws.push_back({$urandom, $urandom});
    send_msg("s512", 2, 2, 99, ws, 8, 0);
    check("s512_b1_lane0", got_blk[2][63:0], 64'h06);
    check("s512_b1_lane8", got_blk[2][64*8 +: 64], 64'h8000_0000_0000_0000);

    // SHA3-224, 18 words, last has 7 bytes
    ws.delete();
    for (int i = 0; i < 18; i++) ws.push_back({$urandom, $urandom});
    send_msg("s224", 5, 5, 99, ws, 7, 0);
    check("s224_top", 64'(got_blk[3][64*17+56 +: 8]), 64'h86);

    // SHAKE128, empty last word at cnt=5, block held 10 cycles
    ws.delete();
    for (int i = 0; i < 6; i++) ws.push_back({$urandom, $urandom});
    send_msg("shk128", 0, 0, 99, ws, 0, 10);
    check("shk128_lane5", got_blk[4][64*5 +: 64], 64'h1F);

    // Mode change after word 3 is ignored
    ws.delete();
    for (int i = 0; i < 20; i++) ws.push_back({$urandom, $urandom});
    send_msg("modechg", 1, 2, 3, ws, 5, 0);

    // Reset while a block is waiting
    mode_sel = 3'd4;
    bus.din = 64'h1234; bus.din_last = 1'b1; bus.din_bytes = 4'd2; bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
    check("ab_valid", 64'(bus.block_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("ab_rst_valid", 64'(bus.block_valid), 64'd0);
    check("ab_rst_busy", 64'(busy), 64'd0);
    check("ab_rst_ready", 64'(bus.din_ready), 64'd0);
    check_block("ab_rst_dout", bus.dout, 1600'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    check("ab_rel_ready", 64'(bus.din_ready), 64'd1);
    ws.delete();
    for (int i = 0; i < 3; i++) ws.push_back({$urandom, $urandom});
    send_msg("after_rst", 4, 4, 99, ws, 4, 0);

    // Random messages
    for (int r = 0; r < 8; r++) begin
      ws.delete();
      for (int i = 0; i < int'($urandom_range(1, 45)); i++) ws.push_back({$urandom, $urandom});
      send_msg("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
               int'($urandom_range(1, 10)), ws, int'($urandom_range(0, 8)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
